// File: rtl/snake_body_tracker.sv
// Snake position/length tracker: steps the head one grid cell per update pulse,
// shifts the segment history, applies growth and flags wall/self collisions.

module snake_seg #(
  parameter int X_BITS = 5,
  parameter int Y_BITS = 5,
  parameter logic [X_BITS-1:0] INIT_X = '0,
  parameter logic [Y_BITS-1:0] INIT_Y = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [X_BITS-1:0] in_x,
  input  logic [Y_BITS-1:0] in_y,
  input  logic [X_BITS-1:0] cmp_x,
  input  logic [Y_BITS-1:0] cmp_y,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              hit
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= INIT_X;
      y <= INIT_Y;
    end else if (load) begin
      x <= INIT_X;
      y <= INIT_Y;
    end else if (shift) begin
      x <= in_x;
      y <= in_y;
    end
  end

  assign hit = (x == cmp_x) && (y == cmp_y);
endmodule

module snake_body_tracker #(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int X_BITS    = 5,
  parameter int Y_BITS    = 5,
  parameter int MAX_LEN   = 8,
  parameter int LEN_BITS  = 4,
  parameter int START_X   = 16,
  parameter int START_Y   = 12,
  parameter int START_LEN = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        update_trigger,
  input  logic [1:0]                  dir_req,
  input  logic                        dir_valid,
  input  logic                        grow,
  input  logic                        restart,
  output logic [X_BITS-1:0]           head_x,
  output logic [Y_BITS-1:0]           head_y,
  output logic [MAX_LEN*X_BITS-1:0]   body_x,
  output logic [MAX_LEN*Y_BITS-1:0]   body_y,
  output logic [LEN_BITS-1:0]         length,
  output logic                        step_done,
  output logic                        game_over
);
  typedef enum logic {RUN, DEAD} state_t;

  localparam logic [1:0]          DIR_UP    = 2'b00;
  localparam logic [1:0]          DIR_RIGHT = 2'b01;
  localparam logic [1:0]          DIR_DOWN  = 2'b10;
  localparam logic [X_BITS-1:0]   X_MAX     = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0]   Y_MAX     = Y_BITS'(GRID_H - 1);
  localparam logic [LEN_BITS-1:0] LEN_MAX   = LEN_BITS'(MAX_LEN);
  localparam logic [LEN_BITS-1:0] LEN_INIT  = LEN_BITS'(START_LEN);

  state_t                           state;
  logic [1:0]                       cur_dir, pend_dir;
  logic                             grow_pending;
  logic [MAX_LEN-1:0][X_BITS-1:0]   sx;
  logic [MAX_LEN-1:0][Y_BITS-1:0]   sy;
  logic [MAX_LEN-1:0]               hit;
  logic [X_BITS-1:0]                nxt_x;
  logic [Y_BITS-1:0]                nxt_y;
  logic                             grow_eff, wall_col, self_col, collide;
  logic                             do_step, do_restart;
  logic [LEN_BITS-1:0]              chk_lim;

  assign grow_eff   = grow_pending | grow;
  assign do_step    = (state == RUN) && update_trigger && !collide;
  assign do_restart = (state == DEAD) && restart;

  always_comb begin
    nxt_x    = sx[0];
    nxt_y    = sy[0];
    wall_col = 1'b0;
    case (pend_dir)
      DIR_UP:    begin nxt_y = sy[0] - 1'b1; wall_col = (sy[0] == '0);   end
      DIR_RIGHT: begin nxt_x = sx[0] + 1'b1; wall_col = (sx[0] == X_MAX); end
      DIR_DOWN:  begin nxt_y = sy[0] + 1'b1; wall_col = (sy[0] == Y_MAX); end
      default:   begin nxt_x = sx[0] - 1'b1; wall_col = (sx[0] == '0);   end
    endcase
  end

  // Without growth the tail moves out this step, so its cell is not checked.
  always_comb begin
    chk_lim  = grow_eff ? length : length - 1'b1;
    self_col = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if (LEN_BITS'(i) < chk_lim && hit[i]) self_col = 1'b1;
  end

  assign collide = wall_col | self_col;

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_seg
    localparam logic [X_BITS-1:0] IX = X_BITS'(START_X - g);
    localparam logic [Y_BITS-1:0] IY = Y_BITS'(START_Y);
    logic [X_BITS-1:0] src_x;
    logic [Y_BITS-1:0] src_y;
    if (g == 0) begin : g_head
      assign src_x = nxt_x;
      assign src_y = nxt_y;
    end else begin : g_body
      assign src_x = sx[g-1];
      assign src_y = sy[g-1];
    end
    snake_seg #(.X_BITS(X_BITS), .Y_BITS(Y_BITS), .INIT_X(IX), .INIT_Y(IY)) u_seg (
      .clk   (clk),
      .reset (reset),
      .load  (do_restart),
      .shift (do_step),
      .in_x  (src_x),
      .in_y  (src_y),
      .cmp_x (nxt_x),
      .cmp_y (nxt_y),
      .x     (sx[g]),
      .y     (sy[g]),
      .hit   (hit[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      length       <= LEN_INIT;
      cur_dir      <= DIR_RIGHT;
      pend_dir     <= DIR_RIGHT;
      grow_pending <= 1'b0;
      step_done    <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      step_done <= 1'b0;
      case (state)
        RUN: begin
          if (dir_valid && dir_req != (cur_dir ^ 2'b10)) pend_dir <= dir_req;
          if (grow) grow_pending <= 1'b1;
          if (update_trigger) begin
            grow_pending <= 1'b0;
            if (collide) begin
              state     <= DEAD;
              game_over <= 1'b1;
            end else begin
              cur_dir   <= pend_dir;
              step_done <= 1'b1;
              if (grow_eff && length < LEN_MAX) length <= length + 1'b1;
            end
          end
        end
        default: begin
          if (restart) begin
            state        <= RUN;
            length       <= LEN_INIT;
            cur_dir      <= DIR_RIGHT;
            pend_dir     <= DIR_RIGHT;
            grow_pending <= 1'b0;
            game_over    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign head_x = sx[0];
  assign head_y = sy[0];
  assign body_x = sx;
  assign body_y = sy;
endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed bench for snake_body_tracker with hand-computed expected positions.

module tb_snake_body_tracker;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        update_trigger = 1'b0;
  logic [1:0]  dir_req = 2'b00;
  logic        dir_valid = 1'b0;
  logic        grow = 1'b0;
  logic        restart = 1'b0;
  logic [4:0]  head_x, head_y;
  logic [39:0] body_x, body_y;
  logic [3:0]  length;
  logic        step_done, game_over;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  snake_body_tracker dut (
    .clk(clk), .reset(reset), .update_trigger(update_trigger), .dir_req(dir_req),
    .dir_valid(dir_valid), .grow(grow), .restart(restart), .head_x(head_x),
    .head_y(head_y), .body_x(body_x), .body_y(body_y), .length(length),
    .step_done(step_done), .game_over(game_over)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sxi(input int i);
    return int'(body_x[i*5 +: 5]);
  endfunction
  function automatic int syi(input int i);
    return int'(body_y[i*5 +: 5]);
  endfunction

  // One clock with the given inputs; returns at the following negedge.
  task automatic cyc(input logic trg, input logic dv, input logic [1:0] dr,
                     input logic gr, input logic rs);
    update_trigger = trg; dir_valid = dv; dir_req = dr; grow = gr; restart = rs;
    @(negedge clk);
    update_trigger = 0; dir_valid = 0; dir_req = 0; grow = 0; restart = 0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag, input int x, input int y);
    chk({tag, ".hx"}, head_x, x);
    chk({tag, ".hy"}, head_y, y);
  endtask

  initial begin
    do_reset();
    chk_head("rst", 16, 12);
    chk("rst.s1x", sxi(1), 15);
    chk("rst.s2x", sxi(2), 14);
    chk("rst.s2y", syi(2), 12);
    chk("rst.len", length, 3);
    chk("rst.go", game_over, 0);
    chk("rst.sd", step_done, 0);

    cyc(1, 0, 0, 0, 0);
    chk_head("step1", 17, 12);
    chk("step1.s1x", sxi(1), 16);
    chk("step1.s2x", sxi(2), 15);
    chk("step1.sd", step_done, 1);
    cyc(0, 0, 0, 0, 0);
    chk("step1.sd_off", step_done, 0);

    // reversal rejected, then a legal turn up
    do_reset();
    cyc(0, 1, 2'b11, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk_head("rev", 17, 12);
    cyc(0, 1, 2'b00, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk_head("up", 17, 11);

    // direction request coincident with trigger applies to the next step
    do_reset();
    cyc(1, 1, 2'b10, 0, 0);
    chk_head("coin1", 17, 12);
    cyc(1, 0, 0, 0, 0);
    chk_head("coin2", 17, 13);

    // growth then self collision
    do_reset();
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk_head("grow", 20, 12);
    chk("grow.len", length, 5);
    cyc(0, 1, 2'b00, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk_head("g.up", 20, 11);
    cyc(0, 1, 2'b11, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk_head("g.left", 19, 11);
    cyc(0, 1, 2'b10, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("self.go", game_over, 1);
    chk("self.sd", step_done, 0);
    chk_head("self", 19, 11);
    chk("self.len", length, 5);

    // pending grow (not coincident) and saturation at MAX_LEN
    do_reset();
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("pend.len", length, 4);
    cyc(1, 0, 0, 0, 0);
    chk("pend.clr", length, 4);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, 0);
    chk("sat.len", length, 8);
    chk_head("sat", 24, 12);

    // tail-cell entry is legal at length 4: right, down, left, up
    do_reset();
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 2'b10, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 2'b11, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 2'b00, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("tail.go", game_over, 0);
    chk_head("tail", 16, 12);

    // wall collision, freeze, restart priority
    do_reset();
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0, 0);
    chk_head("wall15", 31, 12);
    chk("wall15.go", game_over, 0);
    cyc(1, 0, 0, 0, 0);
    chk("wall.go", game_over, 1);
    chk("wall.sd", step_done, 0);
    cyc(1, 1, 2'b00, 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk_head("frz", 31, 12);
    chk("frz.s1x", sxi(1), 30);
    chk("frz.len", length, 3);
    cyc(1, 0, 0, 0, 1);
    chk_head("rs", 16, 12);
    chk("rs.s2x", sxi(2), 14);
    chk("rs.go", game_over, 0);
    chk("rs.sd", step_done, 0);
    chk("rs.len", length, 3);
    cyc(1, 0, 0, 0, 0);
    chk_head("rs.run", 17, 12);

    // async reset in the middle of a cycle
    cyc(1, 0, 0, 1, 0);
    chk("pre.len", length, 4);
    #2 reset = 1'b0;
    #1;
    chk_head("arst", 16, 12);
    chk("arst.len", length, 3);
    chk("arst.sd", step_done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
